// File: rtl/imem_boot_loader.sv
// Boot loader: takes a length-prefixed, XOR-checksummed byte stream and writes 16-bit
// instruction words into instruction memory while holding the CPU core in reset.
module imem_boot_loader #(
   parameter int ADDR_STEP       = 4,
   parameter int MAX_WORDS       = 64,
   parameter bit HOLD_UNTIL_LOAD = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        imem_we,
   output logic [15:0] imem_addr,
   output logic [15:0] imem_wd,
   output logic        cpu_rst,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [15:0] words_loaded
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_LEN_LO,
      S_LEN_HI,
      S_DATA_LO,
      S_DATA_HI,
      S_CHECK,
      S_DONE,
      S_ERROR
   } state_t;

   state_t state, next_state;

   logic        xfer;
   logic [7:0]  len_lo;
   logic [7:0]  lo_byte;
   logic [7:0]  checksum;
   logic [15:0] word_count;
   logic [15:0] frame_len;

   assign frame_len = {in_data, len_lo};
   assign xfer      = in_valid & in_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= next_state;
   end

   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      case (state)
         S_IDLE:    if (start) next_state = S_LEN_LO;
         S_LEN_LO: begin
            in_ready = 1'b1;
            if (xfer) next_state = S_LEN_HI;
         end
         S_LEN_HI: begin
            in_ready = 1'b1;
            if (xfer) begin
               if (frame_len == 16'd0)                  next_state = S_CHECK;
               else if (frame_len > 16'(MAX_WORDS))     next_state = S_ERROR;
               else                                     next_state = S_DATA_LO;
            end
         end
         S_DATA_LO: begin
            in_ready = 1'b1;
            if (xfer) next_state = S_DATA_HI;
         end
         S_DATA_HI: begin
            in_ready = 1'b1;
            if (xfer) begin
               if (words_loaded + 16'd1 == word_count) next_state = S_CHECK;
               else                                    next_state = S_DATA_LO;
            end
         end
         S_CHECK: begin
            in_ready = 1'b1;
            if (xfer) next_state = (in_data == checksum) ? S_DONE : S_ERROR;
         end
         S_DONE:    next_state = S_IDLE;
         S_ERROR:   next_state = S_IDLE;
         default:   next_state = S_IDLE;
      endcase
   end

   // Datapath; the write strobe is registered so it lands the cycle after the hi byte,
   // and the address steps on the edge that ends that strobe.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         imem_we      <= 1'b0;
         imem_addr    <= 16'd0;
         imem_wd      <= 16'd0;
         cpu_rst      <= ~HOLD_UNTIL_LOAD;
         busy         <= 1'b0;
         done         <= 1'b0;
         error        <= 1'b0;
         words_loaded <= 16'd0;
         checksum     <= 8'd0;
         len_lo       <= 8'd0;
         lo_byte      <= 8'd0;
         word_count   <= 16'd0;
      end else begin
         imem_we <= 1'b0;
         if (imem_we) imem_addr <= imem_addr + 16'(ADDR_STEP);

         case (state)
            S_IDLE: begin
               if (start) begin
                  done         <= 1'b0;
                  error        <= 1'b0;
                  words_loaded <= 16'd0;
                  checksum     <= 8'd0;
                  imem_addr    <= 16'd0;
                  cpu_rst      <= 1'b0;
                  busy         <= 1'b1;
               end
            end
            S_LEN_LO: begin
               if (xfer) begin
                  len_lo   <= in_data;
                  checksum <= checksum ^ in_data;
               end
            end
            S_LEN_HI: begin
               if (xfer) begin
                  word_count <= frame_len;
                  checksum   <= checksum ^ in_data;
               end
            end
            S_DATA_LO: begin
               if (xfer) begin
                  lo_byte  <= in_data;
                  checksum <= checksum ^ in_data;
               end
            end
            S_DATA_HI: begin
               if (xfer) begin
                  imem_we      <= 1'b1;
                  imem_wd      <= {in_data, lo_byte};
                  words_loaded <= words_loaded + 16'd1;
                  checksum     <= checksum ^ in_data;
               end
            end
            default: ;
         endcase

         if (state != S_DONE && next_state == S_DONE) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            cpu_rst <= 1'b1;
         end
         if (state != S_ERROR && next_state == S_ERROR) begin
            error <= 1'b1;
            busy  <= 1'b0;
         end
      end
   end

endmodule
